register_scoreboard: RTL and testbench

- Producer-side companion to operand forwarding in the 5-stage RISC-V pipeline.
- Tracks destination registers of instructions in flight between issue (decode→execute handshake) and writeback retirement.
- Raises a decode stall when a source operand cannot be satisfied by forwarding: the youngest in-flight producer of that register is a load, or the per-register in-flight counter is saturated.
- Sits beside decode; driven by the issue and writeback handshakes.

---
 rtl/register_scoreboard.sv | 94 +++++++++
 tb/tb_register_scoreboard.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/register_scoreboard.sv
// In-flight destination-register tracker for the 5-stage pipeline.
// It stalls decode when a source's youngest producer is a load, or when rd's in-flight counter is full.
module register_scoreboard #(
  parameter int NUM_REGS       = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      decode_valid,
  input  logic                      decode_uses_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] decode_rs1,
  input  logic                      decode_uses_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] decode_rs2,
  input  logic                      decode_writes_rd,
  input  logic [REG_ADDR_WIDTH-1:0] decode_rd,
  input  logic                      issue_valid,
  input  logic                      issue_is_load,
  input  logic                      wb_valid,
  input  logic                      wb_writes_rd,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
  output logic                      stall,
  output logic [NUM_REGS-1:0]       busy_mask,
  output logic                      underflow_error
);

  localparam logic [CNT_WIDTH-1:0] MAX = '1;

  logic [CNT_WIDTH-1:0] cnt_q [NUM_REGS];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0]  last_q, last_d;
  logic [NUM_REGS-1:0]  busy_q, busy_d;
  logic                 underflow_q, underflow_d;
  logic                 hit_iss, hit_ret;
  logic                 lh_rs1, lh_rs2, sat_hz;

  // Handshakes: an issue transfers on the cycle issue_valid is high. Upstream guarantees
  // decode_valid && !stall at that point. A retirement transfers on the cycle wb_valid is high.
  // Neither path has a ready signal, so every valid pulse is exactly one event.
  wire issue_ev  = issue_valid && decode_writes_rd && (decode_rd != '0);
  wire retire_ev = wb_valid && wb_writes_rd && (wb_rd != '0);

  always_comb begin
    cnt_d       = cnt_q;
    last_d      = last_q;
    busy_d      = '0;
    underflow_d = underflow_q;
    hit_iss     = 1'b0;
    hit_ret     = 1'b0;
    for (int i = 1; i < NUM_REGS; i++) begin
      hit_iss = issue_ev && (decode_rd == REG_ADDR_WIDTH'(i));
      hit_ret = retire_ev && (wb_rd == REG_ADDR_WIDTH'(i));
      if (hit_iss && hit_ret) begin
        last_d[i] = issue_is_load;
      end else if (hit_iss) begin
        // Overflow can only come from a contract violation, so the counter holds at MAX.
        cnt_d[i]  = (cnt_q[i] == MAX) ? MAX : cnt_q[i] + 1'b1;
        last_d[i] = issue_is_load;
      end else if (hit_ret) begin
        if (cnt_q[i] == '0) underflow_d = 1'b1;
        else                cnt_d[i]    = cnt_q[i] - 1'b1;
      end
      if (cnt_d[i] == '0) last_d[i] = 1'b0;
      busy_d[i] = (cnt_d[i] != '0);
    end
    cnt_d[0]  = '0;
    last_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
      last_q      <= '0;
      busy_q      <= '0;
      underflow_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= cnt_d[i];
      last_q      <= last_d;
      busy_q      <= busy_d;
      underflow_q <= underflow_d;
    end
  end

  always_comb begin
    lh_rs1 = decode_uses_rs1 && (decode_rs1 != '0) && (cnt_q[decode_rs1] != '0) && last_q[decode_rs1];
    lh_rs2 = decode_uses_rs2 && (decode_rs2 != '0) && (cnt_q[decode_rs2] != '0) && last_q[decode_rs2];
    sat_hz = decode_writes_rd && (decode_rd != '0) && (cnt_q[decode_rd] == MAX);
    stall  = !rst && decode_valid && (lh_rs1 || lh_rs2 || sat_hz);
  end

  assign busy_mask       = busy_q;
  assign underflow_error = underflow_q;

endmodule

// File: tb/tb_register_scoreboard.sv
// Directed bench for register_scoreboard with hand-computed expectations.
module tb_register_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        decode_valid, decode_uses_rs1, decode_uses_rs2, decode_writes_rd;
  logic [4:0]  decode_rs1, decode_rs2, decode_rd, wb_rd;
  logic        issue_valid, issue_is_load, wb_valid, wb_writes_rd;
  logic        stall;
  logic [31:0] busy_mask;
  logic        underflow_error;

  int total = 0;
  int bad   = 0;

  register_scoreboard dut (
    .clk(clk), .rst(rst),
    .decode_valid(decode_valid), .decode_uses_rs1(decode_uses_rs1), .decode_rs1(decode_rs1),
    .decode_uses_rs2(decode_uses_rs2), .decode_rs2(decode_rs2),
    .decode_writes_rd(decode_writes_rd), .decode_rd(decode_rd),
    .issue_valid(issue_valid), .issue_is_load(issue_is_load),
    .wb_valid(wb_valid), .wb_writes_rd(wb_writes_rd), .wb_rd(wb_rd),
    .stall(stall), .busy_mask(busy_mask), .underflow_error(underflow_error)
  );

  // clock: rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    decode_valid = 0; decode_uses_rs1 = 0; decode_uses_rs2 = 0; decode_writes_rd = 0;
    decode_rs1 = 0; decode_rs2 = 0; decode_rd = 0;
    issue_valid = 0; issue_is_load = 0;
    wb_valid = 0; wb_writes_rd = 0; wb_rd = 0;
  endtask

  // Ends 1 time unit after a rising edge, so the registered outputs are settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_issue(input logic [4:0] rd, input logic is_load);
    decode_valid = 1; decode_writes_rd = 1; decode_rd = rd;
    issue_valid = 1; issue_is_load = is_load;
    tick();
    clear_inputs();
  endtask

  task automatic do_retire(input logic [4:0] rd);
    wb_valid = 1; wb_writes_rd = 1; wb_rd = rd;
    tick();
    clear_inputs();
  endtask

  // Present a decode candidate without issuing it, then sample the combinational stall.
  task automatic probe(input logic u1, input logic [4:0] r1, input logic u2, input logic [4:0] r2,
                       input logic wr, input logic [4:0] rd, output logic st);
    decode_valid = 1; decode_uses_rs1 = u1; decode_rs1 = r1;
    decode_uses_rs2 = u2; decode_rs2 = r2; decode_writes_rd = wr; decode_rd = rd;
    #1;
    st = stall;
    clear_inputs();
  endtask

  initial begin
    logic st;
    clear_inputs();
    rst = 1;
    #2;
    check("reset_busy", busy_mask, 32'h0);
    check("reset_stall", {31'b0, stall}, 32'h0);
    check("reset_underflow", {31'b0, underflow_error}, 32'h0);
    tick();
    rst = 0;
    tick();

    // Reset mid-operation: two loads to x5 plus an underflow, then an async reset pulse.
    do_issue(5'd5, 1'b1);
    do_issue(5'd5, 1'b1);
    check("x5_busy", busy_mask, 32'h0000_0020);
    probe(1, 5'd5, 0, 5'd0, 0, 5'd0, st);
    check("x5_load_stall", {31'b0, st}, 32'h1);
    do_retire(5'd13);
    check("pre_rst_underflow", {31'b0, underflow_error}, 32'h1);
    decode_valid = 1; decode_uses_rs1 = 1; decode_rs1 = 5'd5;
    #2 rst = 1;
    #1;
    check("async_rst_busy", busy_mask, 32'h0);
    check("async_rst_stall", {31'b0, stall}, 32'h0);
    check("async_rst_underflow", {31'b0, underflow_error}, 32'h0);
    #1 rst = 0;
    clear_inputs();
    tick();

    // Load-use on x3: retiring x3 releases the stall only in the following cycle.
    do_issue(5'd3, 1'b1);
    probe(1, 5'd3, 0, 5'd0, 0, 5'd0, st);
    check("load_use_stall", {31'b0, st}, 32'h1);
    check("x3_busy", busy_mask, 32'h0000_0008);
    probe(0, 5'd0, 1, 5'd3, 0, 5'd0, st);
    check("load_use_rs2_stall", {31'b0, st}, 32'h1);
    decode_valid = 0; decode_uses_rs1 = 1; decode_rs1 = 5'd3;
    #1;
    check("no_decode_valid", {31'b0, stall}, 32'h0);
    clear_inputs();
    decode_valid = 1; decode_uses_rs1 = 1; decode_rs1 = 5'd3;
    wb_valid = 1; wb_writes_rd = 1; wb_rd = 5'd3;
    #1;
    check("retire_same_cycle_stall", {31'b0, stall}, 32'h1);
    tick();
    wb_valid = 0; wb_writes_rd = 0;
    #1;
    check("retire_next_cycle_stall", {31'b0, stall}, 32'h0);
    check("x3_released", busy_mask, 32'h0);
    clear_inputs();

    // ALU producer: forwarding covers it, no stall.
    do_issue(5'd7, 1'b0);
    probe(0, 5'd0, 1, 5'd7, 0, 5'd0, st);
    check("alu_no_stall", {31'b0, st}, 32'h0);
    check("x7_busy", busy_mask, 32'h0000_0080);

    // Youngest wins: a load then an ALU op to x4.
    do_issue(5'd4, 1'b1);
    do_issue(5'd4, 1'b0);
    probe(1, 5'd4, 0, 5'd0, 0, 5'd0, st);
    check("youngest_alu", {31'b0, st}, 32'h0);
    do_retire(5'd4);
    probe(1, 5'd4, 0, 5'd0, 0, 5'd0, st);
    check("youngest_after_retire", {31'b0, st}, 32'h0);
    check("x4_still_busy", busy_mask, 32'h0000_0090);

    // Simultaneous issue (load) and retire on x9 with cnt=1.
    do_issue(5'd9, 1'b0);
    decode_valid = 1; decode_writes_rd = 1; decode_rd = 5'd9;
    issue_valid = 1; issue_is_load = 1;
    wb_valid = 1; wb_writes_rd = 1; wb_rd = 5'd9;
    tick();
    clear_inputs();
    check("x9_busy", busy_mask, 32'h0000_0290);
    probe(1, 5'd9, 0, 5'd0, 0, 5'd0, st);
    check("x9_sim_load_stall", {31'b0, st}, 32'h1);
    do_retire(5'd9);
    check("x9_cleared", busy_mask, 32'h0000_0090);
    probe(1, 5'd9, 0, 5'd0, 0, 5'd0, st);
    check("x9_no_stall", {31'b0, st}, 32'h0);

    // Saturation on x10, including a contract-violating fourth issue.
    for (int k = 0; k < 3; k++) do_issue(5'd10, 1'b0);
    probe(0, 5'd0, 0, 5'd0, 1, 5'd10, st);
    check("sat_stall", {31'b0, st}, 32'h1);
    probe(1, 5'd10, 0, 5'd0, 1, 5'd11, st);
    check("sat_other_rd", {31'b0, st}, 32'h0);
    do_issue(5'd10, 1'b0);
    check("sat_no_wrap", busy_mask, 32'h0000_0490);
    do_retire(5'd10);
    do_retire(5'd10);
    check("sat_two_retired", busy_mask, 32'h0000_0490);
    do_retire(5'd10);
    check("sat_drained", busy_mask, 32'h0000_0090);
    check("sat_no_underflow", {31'b0, underflow_error}, 32'h0);

    // x0 is neither tracked nor retired, and it never stalls.
    do_retire(5'd0);
    check("x0_retire_no_err", {31'b0, underflow_error}, 32'h0);
    do_issue(5'd0, 1'b1);
    check("x0_not_tracked", busy_mask, 32'h0000_0090);
    probe(1, 5'd0, 1, 5'd0, 1, 5'd0, st);
    check("x0_no_stall", {31'b0, st}, 32'h0);

    // Underflow is sticky.
    do_retire(5'd12);
    check("underflow_set", {31'b0, underflow_error}, 32'h1);
    tick();
    tick();
    check("underflow_sticky", {31'b0, underflow_error}, 32'h1);
    check("final_busy", busy_mask, 32'h0000_0090);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
